uart_json_feedback_rx: RTL and testbench

Receives the robot base's serial feedback stream on one GPIO line and decodes the fields the motion logic needs. It is the receive counterpart of the JSON command senders (forward/backwards/stop) that drive the base's UART input. It combines an 8N1 UART receiver with a byte-level parser for flat JSON objects. It presents the last complete frame's `T`, `L` and `R` integer values as held registers, with a one-cycle `frame_valid` strobe.

---
 rtl/uart_json_feedback_rx_if.sv | 24 ++
 rtl/uart_json_feedback_rx.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_uart_json_feedback_rx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_json_feedback_rx_if.sv
// rtl/uart_json_feedback_rx_if.sv - decoded feedback outputs of the UART JSON receiver
interface uart_json_feedback_rx_if #(
    parameter int VAL_W = 16
);
    logic [7:0]              rx_byte;
    logic                    rx_byte_valid;
    logic                    framing_err;
    logic                    parse_err;
    logic                    frame_valid;
    logic signed [VAL_W-1:0] type_code;
    logic signed [VAL_W-1:0] left_val;
    logic signed [VAL_W-1:0] right_val;
    logic [2:0]              fields_seen;

    modport master (
        output rx_byte, rx_byte_valid, framing_err, parse_err, frame_valid,
        output type_code, left_val, right_val, fields_seen
    );

    modport slave (
        input rx_byte, rx_byte_valid, framing_err, parse_err, frame_valid,
        input type_code, left_val, right_val, fields_seen
    );
endinterface

// File: rtl/uart_json_feedback_rx.sv
// rtl/uart_json_feedback_rx.sv - 8N1 UART receiver feeding a flat JSON parser for T/L/R fields
module uart_json_feedback_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int VAL_W        = 16,
    parameter int MAX_LEN      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_in,
    uart_json_feedback_rx_if.master  fb
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam logic [VAL_W-1:0] MAXV = {1'b0, {(VAL_W-1){1'b1}}};

    localparam logic [7:0] CH_LBRACE = 8'h7B, CH_RBRACE = 8'h7D, CH_QUOTE = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A, CH_COMMA  = 8'h2C, CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_DOT    = 8'h2E, CH_T = 8'h54, CH_L = 8'h4C, CH_R = 8'h52;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [3:0] {
        P_WAIT_OPEN, P_KEY_Q1, P_KEY_CH, P_KEY_Q2, P_COLON,
        P_VAL_START, P_VAL_INT, P_VAL_FRAC, P_SEP
    } p_state_t;

    logic sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_in;
            sync2 <= sync1;
        end
    end

    rx_state_t      rx_state, rx_state_n;
    logic [CW-1:0]  rx_cnt, rx_cnt_n;
    logic [2:0]     rx_bit, rx_bit_n;
    logic [7:0]     rx_shift, rx_shift_n, rx_byte_q, rx_byte_n;
    logic           rbv_q, rbv_n, fe_q, fe_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_byte_q <= '0;
            rbv_q     <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            rx_shift  <= rx_shift_n;
            rx_byte_q <= rx_byte_n;
            rbv_q     <= rbv_n;
            fe_q      <= fe_n;
        end
    end

    // Start bit is confirmed at mid-bit; every later sample lands one full bit after the previous.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte_q;
        rbv_n      = 1'b0;
        fe_n       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (!sync2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CW'(HALF - 1)) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {sync2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_n = '0;
                    if (sync2) begin
                        rx_byte_n  = rx_shift;
                        rbv_n      = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        fe_n       = 1'b1;
                        rx_state_n = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                rx_cnt_n = '0;
                if (sync2) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    p_state_t         p_state, p_state_n;
    logic [VAL_W-1:0] acc, acc_n;
    logic             neg, neg_n;
    logic [7:0]       key, key_n;
    logic [LW-1:0]    blen, blen_n;
    logic [VAL_W-1:0] stg_t, stg_t_n, stg_l, stg_l_n, stg_r, stg_r_n;
    logic [2:0]       flags, flags_n;
    logic [VAL_W-1:0] type_q, type_n, left_q, left_n, right_q, right_n;
    logic [2:0]       seen_q, seen_n;
    logic             fv_q, fv_n, pe_q, pe_n;

    logic             is_ws, is_digit;
    logic [VAL_W+3:0] acc_mul;
    logic [VAL_W-1:0] acc_sat, val_s;

    assign is_ws    = (rx_byte_q == 8'h20) || (rx_byte_q == 8'h0D) || (rx_byte_q == 8'h0A);
    assign is_digit = (rx_byte_q >= 8'h30) && (rx_byte_q <= 8'h39);
    assign acc_mul  = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{VAL_W{1'b0}}, rx_byte_q[3:0]};
    assign acc_sat  = (acc_mul > {4'b0, MAXV}) ? MAXV : acc_mul[VAL_W-1:0];
    assign val_s    = neg ? (~acc + VAL_W'(1)) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_WAIT_OPEN;
            acc     <= '0;
            neg     <= 1'b0;
            key     <= '0;
            blen    <= '0;
            stg_t   <= '0;
            stg_l   <= '0;
            stg_r   <= '0;
            flags   <= '0;
            type_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            seen_q  <= '0;
            fv_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            p_state <= p_state_n;
            acc     <= acc_n;
            neg     <= neg_n;
            key     <= key_n;
            blen    <= blen_n;
            stg_t   <= stg_t_n;
            stg_l   <= stg_l_n;
            stg_r   <= stg_r_n;
            flags   <= flags_n;
            type_q  <= type_n;
            left_q  <= left_n;
            right_q <= right_n;
            seen_q  <= seen_n;
            fv_q    <= fv_n;
            pe_q    <= pe_n;
        end
    end

    logic do_store, do_end, do_abort;

    always_comb begin
        p_state_n = p_state;
        acc_n     = acc;
        neg_n     = neg;
        key_n     = key;
        blen_n    = blen;
        stg_t_n   = stg_t;
        stg_l_n   = stg_l;
        stg_r_n   = stg_r;
        flags_n   = flags;
        type_n    = type_q;
        left_n    = left_q;
        right_n   = right_q;
        seen_n    = seen_q;
        fv_n      = 1'b0;
        pe_n      = 1'b0;
        do_store  = 1'b0;
        do_end    = 1'b0;
        do_abort  = 1'b0;

        if (fe_q) begin
            // A corrupted byte drops the frame without reporting a parse error.
            p_state_n = P_WAIT_OPEN;
        end else if (rbv_q) begin
            if (rx_byte_q == CH_LBRACE) begin
                pe_n      = (p_state != P_WAIT_OPEN);
                p_state_n = P_KEY_Q1;
                acc_n     = '0;
                neg_n     = 1'b0;
                flags_n   = '0;
                blen_n    = LW'(1);
            end else if (p_state != P_WAIT_OPEN) begin
                if (blen == LW'(MAX_LEN)) begin
                    do_abort = 1'b1;
                end else begin
                    blen_n = blen + LW'(1);
                    case (p_state)
                        P_KEY_Q1: begin
                            if (rx_byte_q == CH_QUOTE) p_state_n = P_KEY_CH;
                            else if (!is_ws)           do_abort  = 1'b1;
                        end
                        P_KEY_CH: begin
                            if (!is_ws) begin
                                key_n     = rx_byte_q;
                                p_state_n = P_KEY_Q2;
                            end
                        end
                        P_KEY_Q2: begin
                            if (rx_byte_q == CH_QUOTE) p_state_n = P_COLON;
                            else if (!is_ws)           do_abort  = 1'b1;
                        end
                        P_COLON: begin
                            if (rx_byte_q == CH_COLON) begin
                                p_state_n = P_VAL_START;
                                neg_n     = 1'b0;
                                acc_n     = '0;
                            end else if (!is_ws) begin
                                do_abort = 1'b1;
                            end
                        end
                        P_VAL_START: begin
                            if (is_digit) begin
                                acc_n     = {{(VAL_W-4){1'b0}}, rx_byte_q[3:0]};
                                p_state_n = P_VAL_INT;
                            end else if (rx_byte_q == CH_MINUS && !neg) begin
                                neg_n = 1'b1;
                            end else if (!is_ws) begin
                                do_abort = 1'b1;
                            end
                        end
                        P_VAL_INT, P_VAL_FRAC: begin
                            if (is_digit) begin
                                if (p_state == P_VAL_INT) acc_n = acc_sat;
                            end else if (rx_byte_q == CH_DOT && p_state == P_VAL_INT) begin
                                p_state_n = P_VAL_FRAC;
                            end else if (is_ws) begin
                                do_store  = 1'b1;
                                p_state_n = P_SEP;
                            end else if (rx_byte_q == CH_COMMA) begin
                                do_store  = 1'b1;
                                p_state_n = P_KEY_Q1;
                            end else if (rx_byte_q == CH_RBRACE) begin
                                do_store = 1'b1;
                                do_end   = 1'b1;
                            end else begin
                                do_abort = 1'b1;
                            end
                        end
                        P_SEP: begin
                            if (rx_byte_q == CH_COMMA)       p_state_n = P_KEY_Q1;
                            else if (rx_byte_q == CH_RBRACE) do_end    = 1'b1;
                            else if (!is_ws)                 do_abort  = 1'b1;
                        end
                        default: do_abort = 1'b1;
                    endcase
                end
            end
        end

        if (do_store) begin
            case (key)
                CH_T: begin stg_t_n = val_s; flags_n[2] = 1'b1; end
                CH_L: begin stg_l_n = val_s; flags_n[1] = 1'b1; end
                CH_R: begin stg_r_n = val_s; flags_n[0] = 1'b1; end
                default: ;
            endcase
        end

        if (do_abort) begin
            pe_n      = 1'b1;
            p_state_n = P_WAIT_OPEN;
        end

        // Commit uses the staging values just updated by this same closing byte.
        if (do_end) begin
            p_state_n = P_WAIT_OPEN;
            if (flags_n[2]) begin
                fv_n   = 1'b1;
                seen_n = flags_n;
                type_n = stg_t_n;
                if (flags_n[1]) left_n  = stg_l_n;
                if (flags_n[0]) right_n = stg_r_n;
            end else begin
                pe_n = 1'b1;
            end
        end
    end

    assign fb.rx_byte       = rx_byte_q;
    assign fb.rx_byte_valid = rbv_q;
    assign fb.framing_err   = fe_q;
    assign fb.parse_err     = pe_q;
    assign fb.frame_valid   = fv_q;
    assign fb.type_code     = type_q;
    assign fb.left_val      = left_q;
    assign fb.right_val     = right_q;
    assign fb.fields_seen   = seen_q;
endmodule

// File: tb/tb_uart_json_feedback_rx.sv
// tb/tb_uart_json_feedback_rx.sv - bench for uart_json_feedback_rx
module tb_uart_json_feedback_rx;
    localparam int CPB_A = 8;
    localparam int CPB_B = 434;
    localparam int VW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic line_a = 1'b1;
    logic line_b = 1'b1;

    uart_json_feedback_rx_if #(.VAL_W(VW)) fa ();
    uart_json_feedback_rx_if #(.VAL_W(VW)) fbb ();

    uart_json_feedback_rx #(.CLKS_PER_BIT(CPB_A), .VAL_W(VW), .MAX_LEN(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .uart_in(line_a), .fb(fa)
    );
    uart_json_feedback_rx #(.CLKS_PER_BIT(CPB_B), .VAL_W(VW), .MAX_LEN(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .uart_in(line_b), .fb(fbb)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_a = 0, pe_a = 0, fe_a = 0, fe_b = 0;
    int rbv_b_cyc = -1;
    bit prev_rbv_a = 1'b0;
    logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    int m_t = 0, m_l = 0, m_r = 0, m_seen = 0;

    typedef struct {
        string name;
        string text;
        int    fv;
        int    pe;
        int    t;
        int    l;
        int    r;
        int    seen;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fa.frame_valid || fa.parse_err)
            chk("pulse_follows_byte_not_both", {fa.frame_valid && fa.parse_err, prev_rbv_a}, 2'b01);
        if (fa.frame_valid) fv_a++;
        if (fa.parse_err) pe_a++;
        if (fa.framing_err) fe_a++;
        if (fa.rx_byte_valid) got_a.push_back(fa.rx_byte);
        prev_rbv_a = fa.rx_byte_valid;
        if (fbb.framing_err) fe_b++;
        if (fbb.rx_byte_valid) begin
            got_b.push_back(fbb.rx_byte);
            if (rbv_b_cyc < 0) rbv_b_cyc = cyc;
        end
    end

    task automatic line_hold(input int which, input bit v, input int cycles);
        if (which == 0) line_a = v;
        else            line_b = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input int which, input logic [7:0] b, input bit stop_ok);
        int cpb;
        cpb = (which == 0) ? CPB_A : CPB_B;
        line_hold(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) line_hold(which, b[i], cpb);
        line_hold(which, stop_ok, cpb);
        if (stop_ok) begin
            if (which == 0) exp_a.push_back(b);
            else            exp_b.push_back(b);
        end
    endtask

    task automatic send_str_a(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(0, s[i], 1'b1);
    endtask

    task automatic check_rx_a(input string name);
        chk({name, "_rx_count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
            chk({name, "_rx_byte"}, got_a[i], exp_a[i]);
        got_a.delete();
        exp_a.delete();
    endtask

    task automatic apply(input string name, input string s, input int efv, input int epe,
                         input int et, input int el, input int er, input int eseen);
        int fv0, pe0;
        fv0 = fv_a;
        pe0 = pe_a;
        send_str_a(s);
        line_hold(0, 1'b1, 2 * CPB_A);
        chk({name, "_frame_valid"}, fv_a - fv0, efv);
        chk({name, "_parse_err"}, pe_a - pe0, epe);
        chk({name, "_type_code"}, int'(fa.type_code), et);
        chk({name, "_left_val"}, int'(fa.left_val), el);
        chk({name, "_right_val"}, int'(fa.right_val), er);
        chk({name, "_fields_seen"}, fa.fields_seen, eseen);
        check_rx_a(name);
        m_t = et; m_l = el; m_r = er; m_seen = eseen;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_rx_byte"}, fa.rx_byte, 0);
        chk({name, "_pulses"}, {fa.rx_byte_valid, fa.framing_err, fa.parse_err, fa.frame_valid}, 0);
        chk({name, "_type_code"}, int'(fa.type_code), 0);
        chk({name, "_left_val"}, int'(fa.left_val), 0);
        chk({name, "_right_val"}, int'(fa.right_val), 0);
        chk({name, "_fields_seen"}, fa.fields_seen, 0);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        string sp57, sp58;
        sp57 = "";
        for (int i = 0; i < 57; i++) sp57 = {sp57, " "};
        sp58 = {sp57, " "};
        vt.push_back('{"plan_full",   "{\"T\":1001,\"L\":-250,\"R\":37.9}", 1, 0, 1001, -250, 37, 7});
        vt.push_back('{"plan_partial", "{\"T\":5,\"L\":12}",               1, 0, 5, 12, 37, 6});
        vt.push_back('{"no_t",        "{\"L\":3}",                         0, 1, 5, 12, 37, 6});
        vt.push_back('{"bad_value",   "{\"T\":x}",                         0, 1, 5, 12, 37, 6});
        vt.push_back('{"saturate",    "{\"T\":99999}",                     1, 0, 32767, 12, 37, 4});
        vt.push_back('{"whitespace",  "{ \"R\" : -12 , \"T\":0 }\r\n",     1, 0, 0, 12, -12, 5});
        vt.push_back('{"neg_sat_key", "{\"X\":9,\"T\":-32768.5}",          1, 0, -32767, 12, -12, 4});
        vt.push_back('{"restart",     "{\"T\":4,{\"T\":6}",                1, 1, 6, 12, -12, 4});
        vt.push_back('{"long_key",    "{\"TT\":1}",                        0, 1, 6, 12, -12, 4});
        vt.push_back('{"minus_only",  "{\"T\":-}",                         0, 1, 6, 12, -12, 4});
        vt.push_back('{"len_64",      {"{\"T\":2", sp57, "}"},             1, 0, 2, 12, -12, 4});
        vt.push_back('{"len_65",      {"{\"T\":7", sp58, "}"},             0, 1, 2, 12, -12, 4});
        vt.push_back('{"two_dots",    "{\"T\":1.2.3}",                     0, 1, 2, 12, -12, 4});
        vt.push_back('{"garbage_pre", "ab{\"T\":3}",                       1, 0, 3, 12, -12, 4});

        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        fork
            begin
                int c0, fe0, n0;
                c0 = cyc;
                send_byte(1, 8'h55, 1'b1);
                send_byte(1, 8'h00, 1'b1);
                send_byte(1, 8'hFF, 1'b1);
                line_hold(1, 1'b1, 2 * CPB_B);
                chk("b2b_count", got_b.size(), 3);
                for (int i = 0; i < got_b.size() && i < 3; i++) chk("b2b_byte", got_b[i], exp_b[i]);
                chk("b2b_framing_err", fe_b, 0);
                chk("b2b_latency_window", (rbv_b_cyc - c0 >= 4124) && (rbv_b_cyc - c0 <= 4126), 1);
                fe0 = fe_b;
                n0 = got_b.size();
                line_hold(1, 1'b0, 130);
                line_hold(1, 1'b1, 1000);
                chk("glitch_b_bytes", got_b.size(), n0);
                chk("glitch_b_framing", fe_b, fe0);
            end
            begin
                foreach (vt[i])
                    apply(vt[i].name, vt[i].text, vt[i].fv, vt[i].pe, vt[i].t, vt[i].l, vt[i].r, vt[i].seen);

                begin
                    int fv0, pe0, fe0;
                    fv0 = fv_a; pe0 = pe_a; fe0 = fe_a;
                    send_str_a("{\"T\":");
                    send_byte(0, 8'h41, 1'b0);
                    line_hold(0, 1'b1, 2 * CPB_A);
                    chk("midframe_framing_err", fe_a - fe0, 1);
                    chk("midframe_parse_err", pe_a - pe0, 0);
                    chk("midframe_frame_valid", fv_a - fv0, 0);
                    apply("after_framing", "{\"T\":1}", 1, 0, 1, m_l, m_r, 4);
                end

                begin
                    int fv0, pe0, fe0;
                    fv0 = fv_a; pe0 = pe_a; fe0 = fe_a;
                    line_hold(0, 1'b0, 2);
                    line_hold(0, 1'b1, 4 * CPB_A);
                    chk("glitch_a_any_pulse", (fv_a - fv0) + (pe_a - pe0) + (fe_a - fe0) + got_a.size(), 0);
                end

                for (int n = 0; n < 10; n++) begin
                    string s;
                    int nf, vt_, vl_, vr_, efv, epe;
                    bit ht, hl, hr, corrupt;
                    s = "{";
                    ht = 0; hl = 0; hr = 0;
                    vt_ = 0; vl_ = 0; vr_ = 0;
                    nf = $urandom_range(1, 4);
                    for (int f = 0; f < nf; f++) begin
                        int kp, mag, sat, val;
                        bit ng;
                        kp = $urandom_range(0, 9);
                        case ($urandom_range(0, 3))
                            0:       mag = $urandom_range(0, 99);
                            1:       mag = $urandom_range(0, 32767);
                            2:       mag = $urandom_range(32768, 99999);
                            default: mag = $urandom_range(0, 9999);
                        endcase
                        ng  = $urandom_range(0, 1);
                        sat = (mag > 32767) ? 32767 : mag;
                        val = ng ? -sat : sat;
                        if (kp <= 3)      begin s = {s, "\"T\":"}; ht = 1; vt_ = val; end
                        else if (kp <= 6) begin s = {s, "\"L\":"}; hl = 1; vl_ = val; end
                        else if (kp <= 8) begin s = {s, "\"R\":"}; hr = 1; vr_ = val; end
                        else              s = {s, "\"X\":"};
                        if (ng) s = {s, "-"};
                        s = {s, $sformatf("%0d", mag)};
                        if ($urandom_range(0, 2) == 0) s = {s, ".75"};
                        if ($urandom_range(0, 3) == 0) s = {s, " "};
                        if (f != nf - 1) s = {s, ","};
                    end
                    corrupt = ($urandom_range(0, 5) == 0);
                    s = corrupt ? {s, "q}"} : {s, "}"};
                    if (!corrupt && ht) begin
                        efv = 1; epe = 0;
                        m_t = vt_;
                        if (hl) m_l = vl_;
                        if (hr) m_r = vr_;
                        m_seen = {29'd0, ht, hl, hr};
                    end else begin
                        efv = 0; epe = 1;
                    end
                    apply($sformatf("rand%0d", n), s, efv, epe, m_t, m_l, m_r, m_seen);
                end
            end
        join

        send_str_a("{\"T\":7");
        line_hold(0, 1'b0, 3 * CPB_A);
        rst_n  = 1'b0;
        line_a = 1'b1;
        #1;
        check_zero("midbyte_reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        got_a.delete();
        exp_a.delete();
        repeat (4) @(negedge clk);
        apply("after_reset", "{\"T\":8}", 1, 0, 8, 0, 0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
